// File: rtl/segment_chaser_pkg.sv
// Shared constants for the segment fade chaser: mode encoding, bounce
// direction type, default figure-8 step map and output polarity values.
package segment_chaser_pkg;

    // Bounce direction; only meaningful while the chaser is in bounce mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_FWD    = 2'b00;
    localparam logic [1:0] MODE_REV    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam int DEFAULT_SEQ_LEN  = 8;
    localparam int DEFAULT_CH_IDX_W = 3;

    // Figure-8 walk over a 7-segment digit; step 0 sits in the LSBs.
    localparam logic [DEFAULT_SEQ_LEN*DEFAULT_CH_IDX_W-1:0] DEFAULT_SEQ_MAP =
        {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0};

    // Output polarity: common anode drives LEDs low, common cathode high.
    localparam bit CA_ACTIVE_LOW  = 1'b1;
    localparam bit CA_ACTIVE_HIGH = 1'b0;

endpackage

// File: rtl/segment_fade_chaser_if.sv
// Control/LED bundle of the segment fade chaser. The master side drives
// speed and mode; the slave side (the chaser) returns the LED drive,
// the step pulse and the current step index.
interface segment_fade_chaser_if #(
    parameter int NUM_CH  = 8,
    parameter int SPEED_W = 3,
    parameter int POS_W   = 3
);
    logic [SPEED_W-1:0] speed;
    logic [1:0]         mode;
    logic [NUM_CH-1:0]  led_out;
    logic               step_tick;
    logic [POS_W-1:0]   position;

    modport master (
        output speed,
        output mode,
        input  led_out,
        input  step_tick,
        input  position
    );

    modport slave (
        input  speed,
        input  mode,
        output led_out,
        output step_tick,
        output position
    );
endinterface

// File: rtl/chaser_pwm_channel.sv
// One LED channel of the fade chaser: brightness register with force/decay,
// optional gamma stage and a registered PWM compare.
// Optional macro SEGMENT_FADE_GAMMA_EN: compare against (b*b) >> BRIGHT_W
// instead of the linear brightness.
module chaser_pwm_channel #(
    parameter int BRIGHT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_force,
    input  logic                i_decay,
    input  logic [BRIGHT_W-1:0] i_pwm_cnt,
    output logic                o_raw
);

    logic [BRIGHT_W-1:0] r_bright;
    logic [BRIGHT_W-1:0] w_bright_next;
    logic [BRIGHT_W-1:0] w_level;
    logic                r_raw;

    // Force to full scale wins over the per-step halving.
    always_comb begin
        w_bright_next = r_bright;
        if (i_force) begin
            w_bright_next = '1;
        end else if (i_decay) begin
            w_bright_next = r_bright >> 1;
        end
    end

`ifdef SEGMENT_FADE_GAMMA_EN
    logic [2*BRIGHT_W-1:0] w_square;
    assign w_square = r_bright * r_bright;
    assign w_level  = w_square[2*BRIGHT_W-1:BRIGHT_W];
`else
    assign w_level  = r_bright;
`endif

    // Brightness state and the registered PWM compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bright <= '0;
            r_raw    <= 1'b0;
        end else begin
            r_bright <= w_bright_next;
            r_raw    <= (w_level > i_pwm_cnt);
        end
    end

    assign o_raw = r_raw;

endmodule

// File: rtl/segment_fade_chaser.sv
// Multi-channel LED chaser with a geometric fade trail. Holds the step
// prescaler, the position/direction state machine, the PWM counter and the
// output polarity; one chaser_pwm_channel per LED.
// Optional macro SEGMENT_FADE_GAMMA_EN (in chaser_pwm_channel) enables a
// gamma-corrected PWM compare.
module segment_fade_chaser
    import segment_chaser_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int SEQ_LEN    = DEFAULT_SEQ_LEN,
    parameter int CH_IDX_W   = DEFAULT_CH_IDX_W,
    parameter logic [SEQ_LEN*CH_IDX_W-1:0] SEQ_MAP = DEFAULT_SEQ_MAP,
    parameter int BRIGHT_W   = 5,
    parameter int PRESCALE_W = 24,
    parameter int SPEED_W    = 3,
    parameter bit COMMON_ANODE = CA_ACTIVE_LOW
) (
    input  logic                  clk,
    input  logic                  reset,
    segment_fade_chaser_if.slave  bus
);

    localparam int POS_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(SEQ_LEN - 1);
    localparam logic [NUM_CH-1:0] POLARITY =
        (COMMON_ANODE == CA_ACTIVE_HIGH) ? '0 : '1;

    logic [SPEED_W-1:0]    r_speed;
    logic [1:0]            r_mode;
    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] w_cnt_next;
    logic [PRESCALE_W-1:0] w_period;
    logic                  w_tick;
    logic [POS_W-1:0]      r_pos;
    logic [POS_W-1:0]      w_pos_next;
    dir_t                  r_dir;
    dir_t                  w_dir_next;
    logic                  r_step_tick;
    logic [BRIGHT_W-1:0]   r_pwm_cnt;
    logic [CH_IDX_W-1:0]   w_hot_ch;
    logic [NUM_CH-1:0]     w_raw;

    // Control inputs are sampled once; reset deliberately leaves them alone.
    always_ff @(posedge clk) begin
        r_speed <= bus.speed;
        r_mode  <= bus.mode;
    end

    assign w_period = {r_speed, {(PRESCALE_W-SPEED_W){1'b1}}};
    // >= so a step fires promptly when speed is lowered below the count.
    assign w_tick   = (r_cnt >= w_period);

    // State register: prescaler, step position, bounce direction, PWM counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pos       <= '0;
            r_dir       <= DIR_UP;
            r_step_tick <= 1'b0;
            r_pwm_cnt   <= '0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_pos       <= w_pos_next;
            r_dir       <= w_dir_next;
            r_step_tick <= w_tick;
            r_pwm_cnt   <= r_pwm_cnt + 1'b1;
        end
    end

    // Next step position/direction; in bounce the end step is visited once.
    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        w_pos_next = r_pos;
        w_dir_next = r_dir;
        if (w_tick) begin
            w_cnt_next = '0;
            case (r_mode)
                MODE_FWD: w_pos_next = (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
                MODE_REV: w_pos_next = (r_pos == '0) ? LAST_POS : r_pos - 1'b1;
                MODE_BOUNCE: begin
                    if (SEQ_LEN > 1) begin
                        if (r_dir == DIR_UP) begin
                            if (r_pos == LAST_POS) begin
                                w_pos_next = r_pos - 1'b1;
                                w_dir_next = DIR_DOWN;
                            end else begin
                                w_pos_next = r_pos + 1'b1;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_pos_next = r_pos + 1'b1;
                                w_dir_next = DIR_UP;
                            end else begin
                                w_pos_next = r_pos - 1'b1;
                            end
                        end
                    end
                end
                default: w_pos_next = r_pos;
            endcase
        end
    end

    assign w_hot_ch = SEQ_MAP[int'(r_pos)*CH_IDX_W +: CH_IDX_W];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            chaser_pwm_channel #(
                .BRIGHT_W (BRIGHT_W)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .i_force   (w_hot_ch == CH_IDX_W'(gi)),
                .i_decay   (w_tick),
                .i_pwm_cnt (r_pwm_cnt),
                .o_raw     (w_raw[gi])
            );
        end
    endgenerate

    assign bus.led_out   = w_raw ^ POLARITY;
    assign bus.step_tick = r_step_tick;
    assign bus.position  = r_pos;

endmodule

// File: tb/tb_segment_fade_chaser.sv
// Bench for segment_fade_chaser: a directed step table at the fastest rate,
// speed-change corner cases, then randomized modes at the slowest rate with
// per-channel PWM duty measured against a reference brightness model.
module tb_segment_fade_chaser;
    import segment_chaser_pkg::*;

    localparam int NUM_CH   = 8;
    localparam int SEQ_LEN  = 8;
    localparam int BRIGHT_W = 5;
    localparam int MAXB     = (1 << BRIGHT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    segment_fade_chaser_if #(.NUM_CH(8), .SPEED_W(3), .POS_W(3)) bus_a ();
    segment_fade_chaser_if #(.NUM_CH(8), .SPEED_W(3), .POS_W(3)) bus_b ();

    segment_fade_chaser #(.PRESCALE_W(6), .SPEED_W(3), .COMMON_ANODE(CA_ACTIVE_LOW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    segment_fade_chaser #(.PRESCALE_W(6), .SPEED_W(3), .COMMON_ANODE(CA_ACTIVE_HIGH)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        int         exp_pos;
        int         exp_gap;
    } vec_t;
    vec_t tbl[24];
    int t_mode[24] = '{0,0,0,0,0,0,0, 1,1,1, 2,2,2,2,2, 3,3, 1, 2, 0, 2,2,2,2};
    int t_pos[24]  = '{2,3,4,5,6,7,0, 7,6,5, 6,7,6,5,4, 4,4, 3, 2, 3, 2,1,0,1};

    // Reference model state: step index, bounce direction, brightness per channel.
    int m_pos;
    bit m_up;
    int m_b[NUM_CH];
    logic [23:0] map_v = DEFAULT_SEQ_MAP;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sp, input logic [1:0] md);
        bus_a.speed = sp;
        bus_b.speed = sp;
        bus_a.mode  = md;
        bus_b.mode  = md;
    endtask

    // Counts rising edges until step_tick is seen high (sampled on negedge).
    task automatic wait_tick(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus_a.step_tick) ok = 1'b1;
        end
    endtask

    function automatic int map_ch(input int p);
        return int'(map_v[p*3 +: 3]);
    endfunction

    function automatic int exp_level(input int b);
`ifdef SEGMENT_FADE_GAMMA_EN
        return (b * b) >> BRIGHT_W;
`else
        return b;
`endif
    endfunction

    task automatic model_reset();
        m_pos = 0;
        m_up  = 1'b1;
        for (int c = 0; c < NUM_CH; c++) m_b[c] = 0;
        m_b[map_ch(0)] = MAXB;
    endtask

    // One step: the lit channel keeps full scale, the rest halve, then the
    // newly selected channel lights up.
    task automatic model_tick(input int md);
        int old_ch;
        int stp;
        old_ch = map_ch(m_pos);
        for (int c = 0; c < NUM_CH; c++) if (c != old_ch) m_b[c] = m_b[c] / 2;
        m_b[old_ch] = MAXB;
        case (md)
            0: m_pos = (m_pos + 1) % SEQ_LEN;
            1: m_pos = (m_pos + SEQ_LEN - 1) % SEQ_LEN;
            2: begin
                stp = m_up ? 1 : -1;
                if (m_pos + stp < 0 || m_pos + stp >= SEQ_LEN) begin
                    m_up = !m_up;
                    stp  = -stp;
                end
                m_pos = m_pos + stp;
            end
            default: m_pos = m_pos;
        endcase
        m_b[map_ch(m_pos)] = MAXB;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit ok;
        int pend_mode;
        int cnt_a[NUM_CH];
        int cnt_b[NUM_CH];

        for (int i = 0; i < 24; i++) begin
            tbl[i].mode    = 2'(t_mode[i]);
            tbl[i].exp_pos = t_pos[i];
            tbl[i].exp_gap = 8;
        end

        // Reset state.
        drive(3'd0, MODE_FWD);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led_ca", int'(bus_a.led_out), 8'hFF);
        check("rst_led_cc", int'(bus_b.led_out), 8'h00);
        check("rst_position", int'(bus_a.position), 0);
        check("rst_step_tick", int'(bus_a.step_tick), 0);
        reset = 1'b0;

        // First step 8 cycles after release.
        wait_tick(40, n, ok);
        check("first_tick_seen", int'(ok), 1);
        check("first_tick_gap", n, 8);
        check("first_tick_pos", int'(bus_a.position), 1);
        @(posedge clk);
        @(negedge clk);
        check("tick_one_cycle", int'(bus_a.step_tick), 0);
        wait_tick(40, n, ok);
        check("second_tick_gap", n, 7);
        check("second_tick_pos", int'(bus_a.position), 2);

        // Step table: mode applied right after a step takes effect on the next.
        for (int i = 1; i < 24; i++) begin
            drive(3'd0, tbl[i].mode);
            wait_tick(40, n, ok);
            check($sformatf("tbl%0d_gap", i), n, tbl[i].exp_gap);
            check($sformatf("tbl%0d_pos", i), int'(bus_a.position), tbl[i].exp_pos);
            $display("step %0d mode=%0d pos=%0d gap=%0d", i, tbl[i].mode, bus_a.position, n);
        end

        // speed=1 gives a 16-cycle step interval.
        drive(3'd1, MODE_HOLD);
        for (int k = 0; k < 2; k++) begin
            wait_tick(40, n, ok);
            check($sformatf("speed1_gap%0d", k), n, 16);
        end
        // Dropping speed below the running count steps almost immediately.
        repeat (12) @(posedge clk);
        @(negedge clk);
        drive(3'd0, MODE_HOLD);
        wait_tick(40, n, ok);
        check("speed_drop_gap", n, 2);
        wait_tick(40, n, ok);
        check("speed_drop_next_gap", n, 8);

        // Randomized modes at the slowest rate, duty measured per channel.
        pend_mode = $urandom_range(0, 3);
        drive(3'd7, 2'(pend_mode));
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int s = 0; s < 30; s++) begin
            wait_tick(100, n, ok);
            check($sformatf("rnd%0d_gap", s), n, (s == 0) ? 64 : 17);
            model_tick(pend_mode);
            check($sformatf("rnd%0d_pos", s), int'(bus_a.position), m_pos);
            pend_mode = $urandom_range(0, 3);
            drive(3'd7, 2'(pend_mode));
            repeat (16) @(posedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_a[c] = 0;
                cnt_b[c] = 0;
            end
            repeat (32) begin
                @(negedge clk);
                for (int c = 0; c < NUM_CH; c++) begin
                    cnt_a[c] += int'(!bus_a.led_out[c]);
                    cnt_b[c] += int'(bus_b.led_out[c]);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                check($sformatf("rnd%0d_ca_ch%0d_duty", s, c), cnt_a[c], exp_level(m_b[c]));
                check($sformatf("rnd%0d_cc_ch%0d_duty", s, c), cnt_b[c], exp_level(m_b[c]));
            end
            $display("rnd step %0d pos=%0d next_mode=%0d duty_ca=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
                     s, m_pos, pend_mode, cnt_a[0], cnt_a[1], cnt_a[2], cnt_a[3],
                     cnt_a[4], cnt_a[5], cnt_a[6], cnt_a[7]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
